// File: rtl/wb_write_queue.sv
// Write-back queue: buffers register-file writes and replays them in order, one per cycle.
// Optional forwarding of the youngest pending data is enabled with `define WB_QUEUE_FWD_EN.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_a3,
    input  logic [DW-1:0]            in_wd,
    input  logic [DW-1:0]            in_pc,
    input  logic                     drain_en,
    output logic                     rf_we,
    output logic [4:0]               rf_a3,
    output logic [DW-1:0]            rf_wd,
    output logic [DW-1:0]            rf_pc,
    input  logic [4:0]               q_a1,
    input  logic [4:0]               q_a2,
    output logic                     hit1,
    output logic                     hit2,
`ifdef WB_QUEUE_FWD_EN
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    mem_a3 [DEPTH];
    logic [DW-1:0] mem_wd [DEPTH];
    logic [DW-1:0] mem_pc [DEPTH];

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          push_s;
    logic          store_s;
    logic          match1_s;
    logic          match2_s;
    logic [DW-1:0] young1_s;
    logic [DW-1:0] young2_s;

    // Writes to x0 are accepted but never occupy a slot.
    assign rf_we    = (count_r != CW'(0)) && drain_en;
    assign in_ready = (count_r < CW'(DEPTH)) || rf_we;
    assign push_s   = in_valid && in_ready;
    assign store_s  = push_s && (in_a3 != 5'd0);

    assign rf_a3 = mem_a3[rd_ptr_r];
    assign rf_wd = mem_wd[rd_ptr_r];
    assign rf_pc = mem_pc[rd_ptr_r];
    assign count = count_r;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= store_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r <= rf_we   ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
            case ({store_s, rf_we})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are meaningless outside the occupied window
    always_ff @(posedge CLK) begin
        if (store_s) begin
            mem_a3[wr_ptr_r] <= in_a3;
            mem_wd[wr_ptr_r] <= in_wd;
            mem_pc[wr_ptr_r] <= in_pc;
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest one
    always_comb begin
        logic [AW-1:0] slot;
        logic          live;
        logic          m1;
        logic          m2;
        match1_s = 1'b0;
        match2_s = 1'b0;
        young1_s = '0;
        young2_s = '0;
        slot     = rd_ptr_r;
        live     = 1'b0;
        m1       = 1'b0;
        m2       = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            slot     = rd_ptr_r + AW'(k);
            live     = CW'(k) < count_r;
            m1       = live && (mem_a3[slot] == q_a1);
            m2       = live && (mem_a3[slot] == q_a2);
            match1_s = match1_s | m1;
            match2_s = match2_s | m2;
            young1_s = m1 ? mem_wd[slot] : young1_s;
            young2_s = m2 ? mem_wd[slot] : young2_s;
        end
    end

    assign hit1 = (q_a1 != 5'd0) && match1_s;
    assign hit2 = (q_a2 != 5'd0) && match2_s;

`ifdef WB_QUEUE_FWD_EN
    assign fwd1 = hit1 ? young1_s : {DW{1'b0}};
    assign fwd2 = hit2 ? young2_s : {DW{1'b0}};
`endif

endmodule
